// File: rtl/eth_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_fifo_pkg
// Brief    : Shared sizes, status types and accept/flag helpers for the
//            Ethernet 16-entry distributed-RAM FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package eth_fifo_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int PTR_W      = 4;
  localparam int CNT_W      = 5;

  typedef struct packed {
    logic wr;
    logic rd;
  } acc_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  // Accepts are judged purely on the registered (pre-edge) status flags.
  function automatic acc_t fifo_accept(input logic write, input logic read,
                                       input logic full, input logic empty);
    acc_t a;
    a.wr = write & ~full;
    a.rd = read & ~empty;
    return a;
  endfunction

  function automatic flags_t fifo_flags(input logic [CNT_W-1:0] cnt,
                                        input int af_lvl, input int ae_lvl);
    flags_t f;
    f.full         = (cnt == CNT_W'(FIFO_DEPTH));
    f.empty        = (cnt == '0);
    f.almost_full  = (int'(cnt) >= af_lvl);
    f.almost_empty = (int'(cnt) <= ae_lvl);
    return f;
  endfunction

endpackage : eth_fifo_pkg
`default_nettype wire

// File: rtl/eth_dpram16xw.sv
`default_nettype none
// ============================================================================
// Module   : eth_dpram16xw
// Brief    : DATA_WIDTH-wide bank of 16x1 dual-port cells; synchronous write
//            on (we, a, d), asynchronous read on dpra -> dpo. Not reset.
// Revision : 1.0 - initial release
// ============================================================================
module eth_dpram16xw
  import eth_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_W-1:0]      a,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [PTR_W-1:0]      dpra,
  output logic [DATA_WIDTH-1:0] dpo
);

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
    logic [FIFO_DEPTH-1:0] r_cell;

    always_ff @(posedge clk) begin
      if (we) begin
        r_cell[a] <= d[gi];
      end
    end

    assign dpo[gi] = r_cell[dpra];
  end

endmodule : eth_dpram16xw
`default_nettype wire

// File: rtl/eth_dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eth_dpram_fifo_ctrl
// Brief    : 16-entry rate-matching FIFO controller over a distributed
//            dual-port RAM bank. Define ETH_DPRAM_FIFO_OUTREG_EN for a
//            registered data_out; default is first-word-fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module eth_dpram_fifo_ctrl
  import eth_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int ALMOST_FULL_LVL  = 14,
  parameter int ALMOST_EMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam flags_t c_flags_rst = fifo_flags('0, ALMOST_FULL_LVL, ALMOST_EMPTY_LVL);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_cnt;
  flags_t                r_flags;
  logic                  r_ovf;
  logic                  r_unf;

  acc_t                  w_acc;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_cnt_nxt;
  flags_t                w_flags_nxt;
  logic [DATA_WIDTH-1:0] w_dpo;

  assign w_acc  = fifo_accept(write, read, r_flags.full, r_flags.empty);
  // A flush in the same cycle swallows both requests without side effects.
  assign w_push = w_acc.wr & ~clear;
  assign w_pop  = w_acc.rd & ~clear;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clear) begin
      w_cnt_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
        2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  assign w_flags_nxt = fifo_flags(w_cnt_nxt, ALMOST_FULL_LVL, ALMOST_EMPTY_LVL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_flags  <= c_flags_rst;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_flags <= w_flags_nxt;
      r_ovf   <= write & r_flags.full & ~clear;
      r_unf   <= read & r_flags.empty & ~clear;
      if (clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  eth_dpram16xw #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (w_push),
    .a    (r_wr_ptr),
    .d    (data_in),
    .dpra (r_rd_ptr),
    .dpo  (w_dpo)
  );

`ifdef ETH_DPRAM_FIFO_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_data_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
    end else if (w_pop) begin
      r_data_out <= w_dpo;
    end
  end

  assign data_out = r_data_out;
`else
  assign data_out = w_dpo;
`endif

  assign full         = r_flags.full;
  assign empty        = r_flags.empty;
  assign almost_full  = r_flags.almost_full;
  assign almost_empty = r_flags.almost_empty;
  assign cnt          = r_cnt;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule : eth_dpram_fifo_ctrl
`default_nettype wire
